nibble_alu_sequencer: RTL and testbench

Multi-cycle add/subtract unit for the y86 execute stage, built around one 4-bit ripple-carry adder slice. The slice is reused over WIDTH/SLICE cycles to form a WIDTH-bit result plus y86 condition codes (ZF, SF, OF) and a raw carry (CF). Operands arrive on a valid/ready handshake and results leave on one. A synchronous flush lets the pipeline control kill an in-flight operation on a mispredict.

---
 rtl/nibble_alu_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_nibble_alu_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_alu_sequencer.sv
// -----------------------------------------------------------------------------
// nibble_alu_sequencer
//
// Multi-cycle add/subtract unit for the y86 execute stage. A single 4-bit
// ripple-carry slice is stepped over the operands one nibble per cycle,
// LSB first, to build a WIDTH-bit sum/difference plus y86 condition codes.
// Subtraction is a + ~b + 1: B is inverted on accept and the carry chain is
// seeded with 1.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand request valid
//   in_ready   : unit can accept operands (high only in IDLE)
//   op_sub     : 0 = a+b, 1 = a-b (sampled on accept)
//   a, b       : WIDTH-bit operands (sampled on accept)
//   flush      : synchronous kill of the current operation
//   out_valid  : result and flags valid (high only in DONE)
//   out_ready  : consumer takes the result
//   result     : WIDTH-bit sum/difference
//   cf         : raw carry out of the MSB slice (sub: 1 = no borrow)
//   zf, sf, of : zero, sign and signed-overflow flags
// -----------------------------------------------------------------------------
module nibble_alu_sequencer #(
  parameter int WIDTH = 64,  // must be a multiple of SLICE
  parameter int SLICE = 4    // fixed: one 4-bit adder slice
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;      // already inverted for subtract
  logic               r_a_msb;
  logic               r_b_msb;
  logic [WIDTH-1:0]   r_result;
  logic               r_cf;
  logic               r_zf;
  logic               r_sf;
  logic               r_of;

  logic [CNT_W+1:0]   w_lsb;    // bit offset of the current nibble
  logic [SLICE-1:0]   w_a_nib;
  logic [SLICE-1:0]   w_b_nib;
  logic [SLICE-1:0]   w_sum;
  logic               w_ripple;
  logic               w_cout;
  logic               w_last;
  logic               w_accept;
  logic [WIDTH-1:0]   w_final;  // result as it will be after this step

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (flush overrides every transition)
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each always_comb guarantees
  // every path assigns the output, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
    if (flush) begin
      w_next_state = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_CNT);
  assign w_lsb    = {r_cnt, 2'b00};

  // ---------------------------------------------------------------------------
  // 4-bit ripple-carry slice on the currently selected nibble
  // ---------------------------------------------------------------------------
  always_comb begin
    w_a_nib  = r_a[w_lsb +: SLICE];
    w_b_nib  = r_b[w_lsb +: SLICE];
    w_sum    = '0;
    w_ripple = r_carry;
    for (int i = 0; i < SLICE; i++) begin
      w_sum[i] = w_a_nib[i] ^ w_b_nib[i] ^ w_ripple;
      w_ripple = (w_a_nib[i] & w_b_nib[i]) |
                 (w_ripple & (w_a_nib[i] ^ w_b_nib[i]));
    end
    w_cout = w_ripple;
  end

  // Zero flag needs the whole word including the nibble being written now.
  always_comb begin
    w_final                  = r_result;
    w_final[w_lsb +: SLICE]  = w_sum;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_result <= '0;
      r_cf     <= 1'b0;
      r_zf     <= 1'b0;
      r_sf     <= 1'b0;
      r_of     <= 1'b0;
    end else if (flush) begin
      // result and flags keep their last values; they are don't-care
      // while out_valid is low.
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= op_sub ? ~b : b;
      r_carry <= op_sub;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_result[w_lsb +: SLICE] <= w_sum;
      r_carry                  <= w_cout;
      r_cnt                    <= r_cnt + 1'b1;
      if (w_last) begin
        r_cf <= w_cout;
        r_zf <= (w_final == '0);
        r_sf <= w_sum[SLICE-1];
        r_of <= (r_a_msb == r_b_msb) && (w_sum[SLICE-1] != r_a_msb);
      end
    end
  end

  assign result = r_result;
  assign cf     = r_cf;
  assign zf     = r_zf;
  assign sf     = r_sf;
  assign of     = r_of;

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for nibble_alu_sequencer (WIDTH=64). Expected results come from a
// full-width arithmetic model pushed to a scoreboard queue when operands are
// driven and popped when the unit raises out_valid. Inputs change and outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_nibble_alu_sequencer;

  localparam int WIDTH = 64;
  localparam int LAT   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cf;
    logic             zf;
    logic             sf;
    logic             of;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             op_sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             cf, zf, sf, of;

  int   n_cmp = 0;
  int   n_mis = 0;
  obs_t sb_q[$];

  nibble_alu_sequencer #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cf        (cf),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

  function automatic obs_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic sub);
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   s;
    obs_t             f;
    yy    = sub ? ~y : y;
    s     = {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(sub);
    f.res = s[WIDTH-1:0];
    f.cf  = s[WIDTH];
    f.zf  = (f.res == '0);
    f.sf  = f.res[WIDTH-1];
    f.of  = (x[WIDTH-1] == yy[WIDTH-1]) && (f.res[WIDTH-1] != x[WIDTH-1]);
    return f;
  endfunction

  function automatic obs_t observe();
    return {result, cf, zf, sf, of};
  endfunction

  function automatic logic [WIDTH-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Drive operands at a falling edge, push the expectation, return just after
  // the accept edge.
  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic sub);
    @(negedge clk);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    op_sub   = sub;
    sb_q.push_back(model(x, y, sub));
    @(posedge clk);
  endtask

  // Called just after the accept edge. Drops in_valid, scrambles the operand
  // inputs, and returns the number of edges until out_valid is first seen
  // (-1 if it never rises within the budget).
  task automatic wait_done(output int cycles);
    @(negedge clk);
    in_valid = 1'b0;
    a        = rnd64();
    b        = rnd64();
    op_sub   = ~op_sub;
    cycles   = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int   c;
    obs_t e;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      a         = rnd64();
      b         = rnd64();
      op_sub    = 1'($urandom);
      out_ready = 1'($urandom);
      #1;
      n_cmp++;
      if ({out_valid, in_ready, observe()} !== {1'b0, 1'b1, obs_t'('0)}) begin
        n_mis++;
        $display("FAIL reset_state[%0d]: got out_valid=%b in_ready=%b obs=%h, want 0 1 0",
                 i, out_valid, in_ready, observe());
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;

    start_op(64'd3, 64'd4, 1'b0);
    wait_done(c);
    e = sb_q.pop_front();
    n_cmp++;
    if (c !== LAT) begin
      n_mis++;
      $display("FAIL reset_add_latency: got %0d want %0d", c, LAT);
    end
    n_cmp++;
    if (observe() !== e) begin
      n_mis++;
      $display("FAIL reset_add_result: got %h want %h", observe(), e);
    end
    retire();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_mis++;
      $display("FAIL reset_add_retire: got in_ready/out_valid=%b want 10", {in_ready, out_valid});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overflow();
    int   c;
    obs_t e;
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_done(c);
    e = sb_q.pop_front();
    n_cmp++;
    if (c !== LAT) begin
      n_mis++;
      $display("FAIL overflow_latency: got %0d want %0d", c, LAT);
    end
    n_cmp++;
    if (observe() !== e) begin
      n_mis++;
      $display("FAIL overflow_result: got %h want %h", observe(), e);
    end
    retire();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL overflow_retire: got in_ready=%b want 1", in_ready);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_carry_sub();
    logic [WIDTH-1:0] ta[4];
    logic [WIDTH-1:0] tb_[4];
    logic             ts[4];
    int               c;
    obs_t             e;
    ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb_[0] = 64'd1; ts[0] = 1'b0;
    ta[1] = 64'd5;                   tb_[1] = 64'd5; ts[1] = 1'b1;
    ta[2] = 64'd0;                   tb_[2] = 64'd1; ts[2] = 1'b1;
    ta[3] = 64'h8000_0000_0000_0000; tb_[3] = 64'd1; ts[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb_[i], ts[i]);
      wait_done(c);
      e = sb_q.pop_front();
      n_cmp++;
      if (c !== LAT) begin
        n_mis++;
        $display("FAIL carry_sub_latency[%0d]: got %0d want %0d", i, c, LAT);
      end
      n_cmp++;
      if (observe() !== e) begin
        n_mis++;
        $display("FAIL carry_sub_result[%0d]: got %h want %h", i, observe(), e);
      end
      retire();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    int   c;
    obs_t e1;
    obs_t e2;
    start_op(64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b1);
    wait_done(c);
    e1 = sb_q.pop_front();
    n_cmp++;
    if (c !== LAT) begin
      n_mis++;
      $display("FAIL bp_latency: got %0d want %0d", c, LAT);
    end
    // Second request presented while the first result is stalled.
    in_valid = 1'b1;
    a        = 64'h1111_2222_3333_4444;
    b        = 64'h0F0F_0F0F_0F0F_0F0F;
    op_sub   = 1'b0;
    sb_q.push_back(model(a, b, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, observe()} !== {1'b1, 1'b0, e1}) begin
        n_mis++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b obs=%h, want 1 0 %h",
                 i, out_valid, in_ready, observe(), e1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_mis++;
      $display("FAIL bp_release: got in_ready/out_valid=%b want 10", {in_ready, out_valid});
    end
    @(posedge clk);  // second request accepted here
    wait_done(c);
    e2 = sb_q.pop_front();
    n_cmp++;
    if (c !== LAT) begin
      n_mis++;
      $display("FAIL bp_second_latency: got %0d want %0d", c, LAT);
    end
    n_cmp++;
    if (observe() !== e2) begin
      n_mis++;
      $display("FAIL bp_second_result: got %h want %h", observe(), e2);
    end
    retire();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    int   c;
    bit   seen;
    obs_t e;
    start_op(64'hDEAD_BEEF_0000_1234, 64'h0000_0001_FFFF_0001, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    e = sb_q.pop_front();  // killed operation produces no output
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_mis++;
      $display("FAIL flush_idle: got in_ready/out_valid=%b want 10", {in_ready, out_valid});
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_mis++;
      $display("FAIL flush_no_output: got out_valid seen=%b want 0", seen);
    end
    start_op(64'h10, 64'h20, 1'b0);
    wait_done(c);
    e = sb_q.pop_front();
    n_cmp++;
    if (c !== LAT) begin
      n_mis++;
      $display("FAIL flush_next_latency: got %0d want %0d", c, LAT);
    end
    n_cmp++;
    if (observe() !== e) begin
      n_mis++;
      $display("FAIL flush_next_result: got %h want %h", observe(), e);
    end
    retire();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    int   c;
    obs_t e;
    start_op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0F0F, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e = sb_q.pop_front();  // discarded by reset
    n_cmp++;
    if ({out_valid, in_ready, observe()} !== {1'b0, 1'b1, obs_t'('0)}) begin
      n_mis++;
      $display("FAIL async_reset_clear: got out_valid=%b in_ready=%b obs=%h, want 0 1 0",
               out_valid, in_ready, observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0);
    wait_done(c);
    e = sb_q.pop_front();
    n_cmp++;
    if (c !== LAT) begin
      n_mis++;
      $display("FAIL async_reset_next_latency: got %0d want %0d", c, LAT);
    end
    n_cmp++;
    if (observe() !== e) begin
      n_mis++;
      $display("FAIL async_reset_next_result: got %h want %h", observe(), e);
    end
    retire();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_overflow();
    test_carry_sub();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
